div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: 32-bit sequential signed/unsigned divider, one quotient bit per clock.
// clk/rst(async low); start_i/annul_i/signed_div_i/opdata*_i in; result_o/ready_o/busy_o out.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [64:0] w;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [33:0] diff;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    mag1 = opdata1_i;
    mag2 = opdata2_i;
    if (signed_div_i && opdata1_i[31])
      mag1 = ~opdata1_i + 32'd1;
    if (signed_div_i && opdata2_i[31])
      mag2 = ~opdata2_i + 32'd1;
  end

  // Trial subtract on the partial remainder after the left shift.
  // diff[33] is the borrow: set means the divisor did not fit.
  assign diff = w[64:31] - {2'b00, dvsr};

  assign quot = neg_q ? (~w[31:0] + 32'd1) : w[31:0];
  assign rem  = neg_r ? (~w[63:32] + 32'd1) : w[63:32];

  assign busy_o = (state == S_ON) || (state == S_BYZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FREE;
      cnt      <= 6'd0;
      w        <= 65'd0;
      dvsr     <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        S_FREE: begin
          if (start_i && !annul_i) begin
            w     <= {33'd0, mag1};
            dvsr  <= mag2;
            neg_q <= signed_div_i
                     & (opdata1_i[31] ^ opdata2_i[31]);
            neg_r <= signed_div_i & opdata1_i[31];
            cnt   <= 6'd0;
            if (opdata2_i == 32'd0)
              state <= S_BYZERO;
            else
              state <= S_ON;
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            state    <= S_FREE;
            cnt      <= 6'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else begin
            state    <= S_END;
            result_o <= 64'd0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state    <= S_FREE;
            cnt      <= 6'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else if (cnt != 6'd32) begin
            if (!diff[33])
              w <= {diff[32:0], w[30:0], 1'b1};
            else
              w <= {w[63:0], 1'b0};
            cnt <= cnt + 6'd1;
          end else begin
            state    <= S_END;
            result_o <= {rem, quot};
            ready_o  <= 1'b1;
          end
        end
        S_END: begin
          if (!start_i) begin
            state    <= S_FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule
